// File: rtl/gpio_uart_tx.sv
// Change-triggered GPIO trace: queues each new gpio_in value and sends it LSB byte first on 8N1.
// Define GPIO_UART_HEADER_EN to prefix every word with a 0xA5 sync byte.
module gpio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  gpio_in,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         overflow
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned LvlW  = $clog2(DEPTH + 1);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
`ifdef GPIO_UART_HEADER_EN
  localparam int unsigned NumBytes = 5;
`else
  localparam int unsigned NumBytes = 4;
`endif
  localparam int unsigned ShiftW = 8 * NumBytes;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [31:0]     prev_q;
  logic [31:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q;
  logic            overflow_q;

  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        byte_q, byte_d;
  logic [ShiftW-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;

  logic push, pop, full, empty, wr_en, baud_last;

  assign push      = (gpio_in != prev_q);
  assign full      = (level_q == LvlW'(DEPTH));
  assign empty     = (level_q == '0);
  assign pop       = (state_q == StIdle) && !empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign wr_en     = push && (!full || pop);
  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      prev_q <= gpio_in;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !wr_en) level_q <= level_q - 1'b1;
      if (push && !wr_en) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= gpio_in;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
`ifdef GPIO_UART_HEADER_EN
          shift_d = {mem_q[rd_ptr_q], 8'hA5};
`else
          shift_d = mem_q[rd_ptr_q];
`endif
          byte_d  = '0;
          baud_d  = '0;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          // Shifting per bit leaves the next byte at the bottom once 8 bits are out.
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q == 3'(NumBytes - 1)) begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = StStart;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != StIdle);
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Directed bench for gpio_uart_tx: decodes the UART line and checks FIFO/overflow/busy timing.
// Honours GPIO_UART_HEADER_EN for the expected byte stream and word length.
module tb_gpio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef GPIO_UART_HEADER_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int WordCyc = 10 * NB * CPB;

  logic        clk;
  logic        rst;
  logic [31:0] gpio_in;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int busy_total = 0;
  int gap_run = 0;
  int last_gap = -1;

  gpio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_in   (gpio_in),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Busy-cycle total and length of the last idle gap before a word starts.
  always @(negedge clk) begin
    if (busy) begin
      busy_total = busy_total + 1;
      if (gap_run != 0) begin
        last_gap = gap_run;
        gap_run  = 0;
      end
    end else begin
      gap_run = gap_run + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
`ifdef GPIO_UART_HEADER_EN
    return (i == 0) ? 8'hA5 : w[8*(i-1) +: 8];
`else
    return w[8*i +: 8];
`endif
  endfunction

  // skip = start-bit cycles already elapsed at the current negedge.
  task automatic recv_byte(input int skip, output logic [7:0] b);
    int n = 0;
    if (skip == 0) begin
      while (tx !== 1'b0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (tx !== 1'b0) begin
        b = 'x;
        return;
      end
    end
    repeat (CPB + CPB / 2 - skip) @(negedge clk);
    b[0] = tx;
    for (int j = 1; j < 8; j++) begin
      repeat (CPB) @(negedge clk);
      b[j] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit", 40'(tx), 40'd1);
  endtask

  task automatic recv_word(input logic [31:0] w, input int skip);
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
      recv_byte((i == 0) ? skip : 0, b);
      check("rx_byte", 40'(b), 40'(exp_byte(w, i)));
    end
  endtask

  initial begin
    int b0;
    logic [7:0] rb;
    logic [7:0] eb;
    logic [31:0] w;

    rst     = 1'b1;
    gpio_in = 32'h0;
    repeat (3) @(negedge clk);
    check("in_reset", 40'({tx, busy, fifo_level, overflow}), 40'(6'b100000));
    rst = 1'b0;

    // 1: zero input after reset never sends
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      check("idle_zero", 40'({tx, busy, fifo_level, overflow}), 40'(6'b100000));
    end

    // 2: single change, latency and word length
    @(negedge clk);
    b0 = busy_total;
    gpio_in = 32'h1234_5678;
    @(negedge clk);
    check("k_level", 40'(fifo_level), 40'd1);
    check("k_busy", 40'(busy), 40'd0);
    check("k_tx", 40'(tx), 40'd1);
    @(negedge clk);
    check("k1_tx", 40'(tx), 40'd0);
    check("k1_busy", 40'(busy), 40'd1);
    check("k1_level", 40'(fifo_level), 40'd0);
    recv_word(32'h1234_5678, 0);
    repeat (10) @(negedge clk);
    check("busy_cycles", 40'(busy_total - b0), 40'(WordCyc));
    check("busy_done", 40'(busy), 40'd0);

    // 3: burst of changes fills FIFO, sixth is dropped
    gpio_in = 32'd1;
    @(negedge clk);
    gpio_in = 32'd2;
    @(negedge clk);
    check("b_busy", 40'(busy), 40'd1);
    check("b_level1", 40'(fifo_level), 40'd1);
    gpio_in = 32'd3;
    @(negedge clk);
    check("b_level2", 40'(fifo_level), 40'd2);
    gpio_in = 32'd4;
    @(negedge clk);
    check("b_level3", 40'(fifo_level), 40'd3);
    gpio_in = 32'd5;
    @(negedge clk);
    check("b_level4", 40'(fifo_level), 40'd4);
    check("b_no_ovf", 40'(overflow), 40'd0);
    gpio_in = 32'd6;
    @(negedge clk);
    check("b_full_level", 40'(fifo_level), 40'd4);
    check("b_ovf", 40'(overflow), 40'd1);
    recv_word(32'd1, 4);
    // Line sits in the single IDLE cycle; push lands on the popping edge.
    repeat (2) @(negedge clk);
    check("gap_busy", 40'(busy), 40'd0);
    check("gap_level", 40'(fifo_level), 40'd4);
    gpio_in = 32'd7;
    @(negedge clk);
    check("full_push_pop", 40'(fifo_level), 40'd4);
    check("pop_busy", 40'(busy), 40'd1);
    recv_word(32'd2, 0);
    check("gap_w2", 40'(last_gap), 40'd1);
    recv_word(32'd3, 0);
    check("gap_w3", 40'(last_gap), 40'd1);
    recv_word(32'd4, 0);
    check("gap_w4", 40'(last_gap), 40'd1);
    recv_word(32'd5, 0);
    check("gap_w5", 40'(last_gap), 40'd1);
    recv_word(32'd7, 0);
    check("gap_w7", 40'(last_gap), 40'd1);
    repeat (20) @(negedge clk);
    check("b_end", 40'({tx, busy, fifo_level, overflow}), 40'(6'b100001));

    // 4: held value sends exactly one word
    b0 = busy_total;
    gpio_in = 32'hCAFE_F00D;
    recv_word(32'hCAFE_F00D, 0);
    repeat (900) @(negedge clk);
    check("hold_busy_cycles", 40'(busy_total - b0), 40'(WordCyc));
    check("hold_level", 40'(fifo_level), 40'd0);
    check("hold_busy", 40'(busy), 40'd0);

    // 5: async reset in the middle of byte 2
    w = 32'h1122_3344;
    gpio_in = w;
    recv_byte(0, rb);
    check("r_byte0", 40'(rb), 40'(exp_byte(w, 0)));
    recv_byte(0, rb);
    check("r_byte1", 40'(rb), 40'(exp_byte(w, 1)));
    repeat (CPB + CPB / 2) @(negedge clk);
    eb = exp_byte(w, 2);
    check("r_pre_busy", 40'(busy), 40'd1);
    check("r_pre_tx", 40'(tx), 40'(eb[0]));
    #1;
    rst = 1'b1;
    gpio_in = 32'hCAFE_F00D;
    #1;
    check("r_async", 40'({tx, busy, fifo_level, overflow}), 40'(6'b100000));
    @(negedge clk);
    rst = 1'b0;
    b0 = busy_total;
    recv_word(32'hCAFE_F00D, 0);
    repeat (20) @(negedge clk);
    check("r_busy_cycles", 40'(busy_total - b0), 40'(WordCyc));
    check("r_end", 40'({tx, busy, fifo_level, overflow}), 40'(6'b100000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
